// File: rtl/mvau_weight_loader.sv
// Runtime-loadable MVAU weight store for one PE: AXI-Stream writer, 1-cycle registered read.
// Optional tlast framing check enabled by defining WMEM_TLAST_CHECK_EN.
module mvau_weight_loader #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    load_start,
  input  logic [SIMD*TW-1:0]      s_axis_wtdata,
  input  logic                    s_axis_wtvalid,
  output logic                    s_axis_wtready,
`ifdef WMEM_TLAST_CHECK_EN
  input  logic                    s_axis_wtlast,
  output logic                    load_err,
`endif
  input  logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic [SIMD*TW-1:0]      wmem_out,
  output logic                    wmem_ready,
  output logic                    load_done
);

  localparam int DW = SIMD * TW;
  localparam int MW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
  localparam logic [WMEM_ADDR_BW-1:0] LAST =
    WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [WMEM_ADDR_BW:0] DEPTH =
    (WMEM_ADDR_BW + 1)'(WMEM_DEPTH);

  typedef enum logic {
    S_LOAD,
    S_READY
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WMEM_ADDR_BW-1:0] r_wr_ptr;
  logic [WMEM_ADDR_BW-1:0] w_wr_ptr_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic [DW-1:0]           r_out;
  logic [DW-1:0]           w_out_nxt;
  logic                    w_beat;
  logic                    w_rd_hit;
  logic [MW-1:0]           w_wr_idx;
  logic [MW-1:0]           w_rd_idx;

  (* ram_style = "auto" *)
  logic [DW-1:0] mem [WMEM_DEPTH];

  assign s_axis_wtready = (r_state == S_LOAD);
  assign w_beat   = s_axis_wtvalid & s_axis_wtready;
  assign w_wr_idx = r_wr_ptr[MW-1:0];
  assign w_rd_idx = wmem_addr[MW-1:0];
  assign w_rd_hit = ({1'b0, wmem_addr} < DEPTH);

  // Contents survive reset; only a new load overwrites them.
  always_ff @(posedge aclk) begin
    if (w_beat) begin
      mem[w_wr_idx] <= s_axis_wtdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_LOAD;
      r_wr_ptr <= '0;
      r_done   <= 1'b0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_done   <= w_done_nxt;
      r_out    <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_done_nxt   = 1'b0;
    w_out_nxt    = '0;
    unique case (r_state)
      S_LOAD: begin
        if (w_beat) begin
          if (r_wr_ptr == LAST) begin
            w_wr_ptr_nxt = '0;
            w_state_nxt  = S_READY;
            w_done_nxt   = 1'b1;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + WMEM_ADDR_BW'(1);
          end
        end
      end
      S_READY: begin
        // The read on the load_start edge still completes.
        if (w_rd_hit) begin
          w_out_nxt = mem[w_rd_idx];
        end
        if (load_start) begin
          w_state_nxt  = S_LOAD;
          w_wr_ptr_nxt = '0;
        end
      end
    endcase
  end

  assign wmem_out   = r_out;
  assign wmem_ready = (r_state == S_READY);
  assign load_done  = r_done;

`ifdef WMEM_TLAST_CHECK_EN
  logic r_err;
  logic w_frame_bad;

  // tlast must mark exactly the final word; the load still ends by count.
  assign w_frame_bad = w_beat & (s_axis_wtlast ^ (r_wr_ptr == LAST));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err <= 1'b0;
    end else if ((r_state == S_READY) && load_start) begin
      r_err <= 1'b0;
    end else if (w_frame_bad) begin
      r_err <= 1'b1;
    end
  end

  assign load_err = r_err;
`endif

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Scoreboard bench for mvau_weight_loader: reads queue expected data, a monitor checks it.
// Defining WMEM_TLAST_CHECK_EN also exercises the framing check.
module tb_mvau_weight_loader;

  localparam int DW = 2;
  localparam int AW = 4;

  logic          aclk;
  logic          aresetn;
  logic          load_start;
  logic [DW-1:0] wtdata;
  logic          wtvalid;
  logic          wtready;
  logic [AW-1:0] wmem_addr;
  logic [DW-1:0] wmem_out;
  logic          wmem_ready;
  logic          load_done;
`ifdef WMEM_TLAST_CHECK_EN
  logic          wtlast;
  logic          load_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic          rd_req;
  logic          rd_q;
  logic [DW-1:0] exp_q[$];

  mvau_weight_loader #(
    .SIMD(2),
    .TW(1),
    .WMEM_DEPTH(4),
    .WMEM_ADDR_BW(AW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .load_start(load_start),
    .s_axis_wtdata(wtdata),
    .s_axis_wtvalid(wtvalid),
    .s_axis_wtready(wtready),
`ifdef WMEM_TLAST_CHECK_EN
    .s_axis_wtlast(wtlast),
    .load_err(load_err),
`endif
    .wmem_addr(wmem_addr),
    .wmem_out(wmem_out),
    .wmem_ready(wmem_ready),
    .load_done(load_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) rd_q <= rd_req;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each read issued one cycle earlier owns the head of the queue.
  always @(negedge aclk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: read with no expected entry at %0t", $time);
      end else begin
        chk("sb_rdata", wmem_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    wmem_addr = a;
    rd_req    = 1'b1;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic rd_end();
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_load(input logic [AW-1:0] a, input logic [DW-1:0] e);
    load_start = 1'b1;
    rd(a, e);
    load_start = 1'b0;
    chk("start_ready_low", wmem_ready, 0);
    chk("start_tready", wtready, 1);
    rd(a, 0);
    rd_req = 1'b0;
  endtask

  task automatic load4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                       input logic [3:0] lastm, input bit mid_start);
    logic [DW-1:0] d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      chk("load_tready", wtready, 1);
      chk("load_done_low", load_done, 0);
      wtvalid    = 1'b1;
      wtdata     = d[i];
      load_start = mid_start && (i == 2);
`ifdef WMEM_TLAST_CHECK_EN
      wtlast     = lastm[i];
`endif
      tick();
    end
    wtvalid    = 1'b0;
    load_start = 1'b0;
`ifdef WMEM_TLAST_CHECK_EN
    wtlast     = 1'b0;
`endif
    chk("load_done", load_done, 1);
    chk("load_ready", wmem_ready, 1);
    chk("ready_tready", wtready, 0);
    tick();
    chk("done_one_cycle", load_done, 0);
    chk("ready_hold", wmem_ready, 1);
  endtask

  initial begin
    aresetn    = 1'b0;
    load_start = 1'b0;
    wtdata     = '0;
    wtvalid    = 1'b0;
    wmem_addr  = '0;
    rd_req     = 1'b0;
`ifdef WMEM_TLAST_CHECK_EN
    wtlast     = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_out", wmem_out, 0);
    chk("rst_ready", wmem_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_tready", wtready, 1);
`ifdef WMEM_TLAST_CHECK_EN
    chk("rst_err", load_err, 0);
`endif
    aresetn = 1'b1;
    tick();

    // Basic back-to-back load and readback, including out-of-range address.
    load4(2'h1, 2'h2, 2'h3, 2'h0, 4'b1000, 1'b0);
    rd(0, 2'h1);
    rd(1, 2'h2);
    rd(2, 2'h3);
    rd(3, 2'h0);
    rd(5, 2'h0);
    rd_end();

    // Reload with tvalid gaps: 1,0,0,1,1,0,1.
    start_load(1, 2'h2);
    begin
      logic [6:0] vm;
      logic [DW-1:0] dv[7];
      vm = 7'b1011001;
      dv = '{2'h3, 2'h1, 2'h2, 2'h2, 2'h1, 2'h0, 2'h3};
      for (int i = 0; i < 7; i++) begin
        chk("gap_done_low", load_done, 0);
        wtvalid = vm[i];
        wtdata  = dv[i];
`ifdef WMEM_TLAST_CHECK_EN
        wtlast  = (i == 6);
`endif
        tick();
      end
      wtvalid = 1'b0;
`ifdef WMEM_TLAST_CHECK_EN
      wtlast  = 1'b0;
`endif
      chk("gap_done", load_done, 1);
      chk("gap_ready", wmem_ready, 1);
    end
    rd(0, 2'h3);
    rd(1, 2'h2);
    rd(2, 2'h1);
    rd(3, 2'h3);
    rd_end();

    // Reload with a load_start pulse mid-load that must be ignored.
    start_load(0, 2'h3);
    load4(2'h0, 2'h0, 2'h3, 2'h3, 4'b1000, 1'b1);
    rd(0, 2'h0);
    rd(1, 2'h0);
    rd(2, 2'h3);
    rd(3, 2'h3);
    rd_end();

    // Asynchronous reset while the read register holds data.
    wmem_addr = 3;
    tick();
    chk("pre_rst_out", wmem_out, 3);
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_out", wmem_out, 0);
    chk("async_rst_ready", wmem_ready, 0);
    chk("async_rst_tready", wtready, 1);
    tick();
    aresetn = 1'b1;
    tick();

    // Partial load abandoned by reset; next load restarts at address 0.
    wtvalid = 1'b1;
    wtdata  = 2'h1;
    tick();
    tick();
    wtvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("midload_rst_ready", wmem_ready, 0);
    chk("midload_rst_out", wmem_out, 0);
    tick();
    aresetn = 1'b1;
    tick();
    load4(2'h2, 2'h1, 2'h3, 2'h0, 4'b1000, 1'b0);
    rd(0, 2'h2);
    rd(1, 2'h1);
    rd(2, 2'h3);
    rd(3, 2'h0);
    rd_end();

`ifdef WMEM_TLAST_CHECK_EN
    // Early tlast on beat 3 flags a sticky error; load_start clears it.
    start_load(0, 2'h2);
    chk("err_clear0", load_err, 0);
    load4(2'h1, 2'h1, 2'h1, 2'h1, 4'b0100, 1'b0);
    chk("err_sticky", load_err, 1);
    tick();
    chk("err_hold", load_err, 1);
    start_load(1, 2'h1);
    chk("err_cleared", load_err, 0);
    load4(2'h2, 2'h2, 2'h2, 2'h2, 4'b1000, 1'b0);
    chk("err_good_frame", load_err, 0);
`endif

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvau_weight_loader.md
Name: mvau_weight_loader

Overview:
- Writer side of the MVAU weight memory: a writable weight store for one PE.
- Accepts a stream of SIMD*TW-bit weight words on an AXI-Stream slave and writes them sequentially into an internal RAM of WMEM_DEPTH words.
- After a complete load, the RAM serves the MVAU read port with the same 1-cycle registered read the fixed weight memory provides.
- Allows weights to be (re)loaded at runtime instead of through a memory initialisation file.

Parameters:
- SIMD, 2, input channels processed per cycle; word width factor.
- TW, 1, weight bit width.
- WMEM_DEPTH, 4, number of words, (KDim^2*IFMCh*OFMCh)/(SIMD*PE).
- WMEM_ADDR_BW, 4, address width; must satisfy 2^WMEM_ADDR_BW >= WMEM_DEPTH.

Ports:
- aclk, in, 1, main clock, rising edge.
- aresetn, in, 1, asynchronous active-low reset.
- load_start, in, 1, single-cycle request to reload weights; honoured only in S_READY.
- s_axis_wtdata, in, SIMD*TW, weight word to write.
- s_axis_wtvalid, in, 1, weight word valid.
- s_axis_wtready, out, 1, loader accepts a word.
- s_axis_wtlast, in, 1, last word of load; present only with WMEM_TLAST_CHECK_EN.
- wmem_addr, in, WMEM_ADDR_BW, read address from the MVAU control.
- wmem_out, out, SIMD*TW, registered read data.
- wmem_ready, out, 1, RAM contents complete and readable.
- load_done, out, 1, one-cycle pulse when the final word is written.
- load_err, out, 1, sticky framing error; present only with WMEM_TLAST_CHECK_EN.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - state=S_LOAD, wr_ptr=0.
  - wmem_out=0, wmem_ready=0, load_done=0, load_err=0.
  - RAM contents are not cleared.
- s_axis_wtready is combinational: 1 exactly when state==S_LOAD. A beat is a cycle with tvalid & tready.
- S_LOAD:
  - Each beat writes mem[wr_ptr] <= s_axis_wtdata and increments wr_ptr.
  - Gaps in tvalid stall the load without penalty.
  - A beat at wr_ptr==WMEM_DEPTH-1 writes the word, sets wr_ptr=0 and moves to S_READY on the next edge.
  - load_done=1 for exactly the cycle following that beat, coincident with the first S_READY cycle. wmem_ready=1 from that cycle onward.
  - wmem_out is held at 0 throughout S_LOAD.
  - load_start is ignored in S_LOAD.
- S_READY:
  - tready=0.
  - Every cycle, wmem_out <= mem[wmem_addr], 1-cycle latency, no enable.
  - If wmem_addr >= WMEM_DEPTH, wmem_out <= 0.
  - load_start=1 moves the state to S_LOAD at the next edge. wmem_ready=0 and tready=1 from that next cycle; wr_ptr restarts at 0.
  - On the load_start edge the read still completes normally.
- Simultaneous events:
  - In S_READY, stream traffic is ignored because tready=0; upstream holds the data.
  - Reset mid-load abandons the partial load; the next load starts at address 0.
- Write/read collision is impossible: writes only in S_LOAD, reads only in S_READY.
- wr_ptr width is WMEM_ADDR_BW; it never exceeds WMEM_DEPTH-1.
- WMEM_DEPTH=1 is legal: the first beat completes the load.
- RAM is inferred (ram_style "auto"): one write port, one registered read port.

Optional Feature:
- Macro: WMEM_TLAST_CHECK_EN.
- Defined:
  - s_axis_wtlast and load_err ports exist.
  - load_err is set sticky when a beat has tlast=1 with wr_ptr != WMEM_DEPTH-1, or tlast=0 with wr_ptr == WMEM_DEPTH-1.
  - The load still completes by count only.
  - load_err is cleared by reset or by an accepted load_start.
- Undefined: neither port exists, no check logic is present, and behaviour is otherwise identical.

Test Plan:
- Basic load (SIMD=2, TW=1, DEPTH=4): reset, then beats 0x1,0x2,0x3,0x0 back-to-back -> tready high for 4 cycles then 0; load_done pulses once the cycle after the 4th beat; wmem_ready=1.
- Read latency: after the load, drive wmem_addr=0,1,2,3 on consecutive cycles -> wmem_out=0x1,0x2,0x3,0x0 one cycle after each address. wmem_addr=5 -> wmem_out=0.
- Backpressure and gaps: tvalid toggled 1,0,0,1,1,0,1 carrying 0x3,0x2,0x1,0x3 -> exactly 4 writes; readback 0x3,0x2,0x1,0x3; load_done occurs after the 7th stimulus cycle.
- Reload: load_start in S_READY -> wmem_ready=0 and tready=1 next cycle; load 0x0,0x0,0x3,0x3 -> readback matches the new data. load_start pulsed mid-load -> no effect.
- Reset mid-operation: assert aresetn=0 asynchronously after 2 beats -> wmem_out=0 and wmem_ready=0 immediately; after release, 4 new beats complete the load and readback shows only the new data.
- With WMEM_TLAST_CHECK_EN: tlast on the 3rd of 4 beats -> load_err=1 and remains 1 after load_done; the next load_start clears it; a correctly framed load leaves it 0.
